// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit counter encodings and index sizing.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt2_e;

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for one up/down saturating counter.
module bp_sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             taken,
    output logic [CNT_W-1:0] cnt_nxt
);

    always_comb begin
        cnt_nxt = cnt;
        unique case (1'b1)
            taken && (cnt != '1): cnt_nxt = cnt + 1'b1;
            !taken && (cnt != '0): cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

endmodule

// File: rtl/bp_bht_table.sv
// Branch history table of saturating counters, bimodal by default.
// Define BP_GSHARE_EN to XOR a global history register into the index.
module bp_bht_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int HIST_W  = 6,
    parameter int PC_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             pred_taken,
    output logic [idx_width(ENTRIES)-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [idx_width(ENTRIES)-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    output logic [15:0]      mispred_cnt
);

    localparam int IDX_W = idx_width(ENTRIES);

    logic [CNT_W-1:0] tbl_q [ENTRIES];
    logic [CNT_W-1:0] tbl_d [ENTRIES];
    logic [CNT_W-1:0] upd_cnt_nxt;
    logic [15:0]      mispred_cnt_q;
    logic [15:0]      mispred_cnt_d;
    logic [IDX_W-1:0] base_idx;
    logic             pc_unused;

    assign base_idx  = lookup_pc[IDX_W+1:2];
    assign pc_unused = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] ghr_q;
    logic [HIST_W-1:0] ghr_d;
    logic [IDX_W-1:0]  ghr_ext;

    always_comb begin
        ghr_ext = '0;
        ghr_ext[HIST_W-1:0] = ghr_q;
    end

    generate
        if (HIST_W == 1) begin : g_hist1
            assign ghr_d = upd_valid ? upd_taken : ghr_q;
        end else begin : g_histn
            assign ghr_d = upd_valid ? {ghr_q[HIST_W-2:0], upd_taken}
                                     : ghr_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) ghr_q <= '0;
        else       ghr_q <= ghr_d;
    end

    assign pred_idx = base_idx ^ ghr_ext;
`else
    assign pred_idx = base_idx;
`endif

    // Reads see the registered table, so a same-cycle update is not bypassed.
    assign pred_taken  = tbl_q[pred_idx][CNT_W-1];
    assign mispred_cnt = mispred_cnt_q;

    bp_sat_counter #(
        .CNT_W   (CNT_W)
    ) u_sat (
        .cnt     (tbl_q[upd_idx]),
        .taken   (upd_taken),
        .cnt_nxt (upd_cnt_nxt)
    );

    always_comb begin
        tbl_d = tbl_q;
        if (upd_valid) tbl_d[upd_idx] = upd_cnt_nxt;
    end

    always_comb begin
        mispred_cnt_d = mispred_cnt_q;
        if (upd_valid && upd_mispredict && (mispred_cnt_q != 16'hFFFF))
            mispred_cnt_d = mispred_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
            mispred_cnt_q <= '0;
        end else begin
            tbl_q         <= tbl_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_bp_bht_table.sv
// Directed self-checking bench for bp_bht_table (default parameters).
module tb_bp_bht_table;

    logic        clk;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [5:0]  pred_idx;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [15:0] mispred_cnt;

    int n_tests;
    int n_fail;

    bp_bht_table dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_pc      (lookup_pc),
        .pred_taken     (pred_taken),
        .pred_idx       (pred_idx),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [5:0] idx, input logic tk,
                       input logic mis);
        upd_valid      = 1'b1;
        upd_idx        = idx;
        upd_taken      = tk;
        upd_mispredict = mis;
        step();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic pred_at(input logic [31:0] pc, input string tag,
                           input logic exp);
        lookup_pc = pc;
        #1;
        check(tag, {31'd0, pred_taken}, {31'd0, exp});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        lookup_pc = 32'h14;
        upd_valid = 1'b0;
        upd_idx = '0;
        upd_taken = 1'b0;
        upd_mispredict = 1'b0;
        step();
        step();
        reset = 1'b0;

        pred_at(32'h14, "rst_pred_14", 1'b0);
        pred_at(32'hFC, "rst_pred_fc", 1'b0);
        check("rst_mispred", {16'd0, mispred_cnt}, 32'd0);
        lookup_pc = 32'h14; #1;
        check("idx_14", {26'd0, pred_idx}, 32'd5);
        lookup_pc = 32'hFC; #1;
        check("idx_fc", {26'd0, pred_idx}, 32'd63);
        lookup_pc = 32'h100; #1;
        check("idx_wrap", {26'd0, pred_idx}, 32'd0);

        // Training up to saturation
        upd(6'd5, 1'b1, 1'b0);
        pred_at(32'h14, "train1", 1'b0);
        upd(6'd5, 1'b1, 1'b0);
        pred_at(32'h14, "train2", 1'b1);
        pred_at(32'h18, "train_other", 1'b0);
        upd(6'd5, 1'b1, 1'b0);
        upd(6'd5, 1'b1, 1'b0);
        pred_at(32'h14, "train4", 1'b1);

        // De-saturation and floor
        upd(6'd5, 1'b0, 1'b0);
        pred_at(32'h14, "desat1", 1'b1);
        upd(6'd5, 1'b0, 1'b0);
        pred_at(32'h14, "desat2", 1'b0);
        upd(6'd5, 1'b0, 1'b0);
        upd(6'd5, 1'b0, 1'b0);
        upd(6'd5, 1'b0, 1'b0);
        upd(6'd5, 1'b1, 1'b0);
        pred_at(32'h14, "floor_up1", 1'b0);

        // Collision: counter is 1, taken update in the lookup cycle
        lookup_pc      = 32'h14;
        upd_valid      = 1'b1;
        upd_idx        = 6'd5;
        upd_taken      = 1'b1;
        #1;
        check("coll_same", {31'd0, pred_taken}, 32'd0);
        step();
        upd_valid = 1'b0;
        check("coll_next", {31'd0, pred_taken}, 32'd1);

        // Mispredict counting
        upd(6'd9, 1'b1, 1'b1);
        upd(6'd9, 1'b1, 1'b1);
        upd(6'd9, 1'b1, 1'b1);
        check("mis_3", {16'd0, mispred_cnt}, 32'd3);
        upd_mispredict = 1'b1;
        for (int i = 0; i < 5; i++) step();
        upd_mispredict = 1'b0;
        check("mis_novalid", {16'd0, mispred_cnt}, 32'd3);
        upd(6'd9, 1'b1, 1'b0);
        check("mis_nomis", {16'd0, mispred_cnt}, 32'd3);
        upd_valid      = 1'b1;
        upd_idx        = 6'd9;
        upd_taken      = 1'b1;
        upd_mispredict = 1'b1;
        for (int i = 0; i < 65537; i++) step();
        upd_valid      = 1'b0;
        check("mis_sat", {16'd0, mispred_cnt}, 32'h0000FFFF);
        upd_mispredict = 1'b1;
        step();
        upd_mispredict = 1'b0;
        check("mis_sat_hold", {16'd0, mispred_cnt}, 32'h0000FFFF);

        // Reset with a coincident update
        reset          = 1'b1;
        upd_valid      = 1'b1;
        upd_idx        = 6'd7;
        upd_taken      = 1'b1;
        upd_mispredict = 1'b1;
        step();
        reset          = 1'b0;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        pred_at(32'h14, "rst2_pred_14", 1'b0);
        pred_at(32'h24, "rst2_pred_24", 1'b0);
        pred_at(32'h1C, "rst2_pred_1c", 1'b0);
        check("rst2_mispred", {16'd0, mispred_cnt}, 32'd0);
        upd(6'd7, 1'b1, 1'b0);
        pred_at(32'h1C, "rst2_lost", 1'b0);
        upd(6'd7, 1'b1, 1'b0);
        pred_at(32'h1C, "rst2_after2", 1'b1);

`ifdef BP_GSHARE_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        upd(6'd0, 1'b1, 1'b0);
        upd(6'd0, 1'b1, 1'b0);
        upd(6'd0, 1'b0, 1'b0);
        lookup_pc = 32'h14; #1;
        check("gshare_idx", {26'd0, pred_idx}, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_bht_table.md
BP_BHT_TABLE -- requirements
Module: bp_bht_table

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of counters in the table (power of 2, >= 4).
REQ-002 SHALL have parameter CNT_W, default 2, width of each saturating counter (>= 1).
REQ-003 SHALL have parameter HIST_W, default 6, global history length (1..IDX_W).
REQ-004 SHALL have parameter PC_W, default 32, program-counter width.
REQ-005 SHALL use IDX_W = log2(ENTRIES) as a derived localparam.
REQ-006 SHALL have port clk  in  1  clock; all state changes on the rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port lookup_pc  in  PC_W  fetch PC of the branch to predict.
REQ-009 SHALL have port pred_taken  out  1  prediction: MSB of the indexed counter.
REQ-010 SHALL have port pred_idx  out  IDX_W  index used for this prediction; the pipeline carries it back as upd_idx.
REQ-011 SHALL have port upd_valid  in  1  resolved branch update strobe (replaces the old Branch input).
REQ-012 SHALL have port upd_idx  in  IDX_W  table index to train.
REQ-013 SHALL have port upd_taken  in  1  resolved outcome (replaces the old Zero input).
REQ-014 SHALL have port upd_mispredict  in  1  resolved outcome differed from the issued prediction.
REQ-015 SHALL have port mispred_cnt  out  16  saturating count of mispredicted updates.

Function
REQ-016 SHALL compute pred_idx and pred_taken combinationally from lookup_pc and current state, with zero-cycle latency.
REQ-017 SHALL, when the macro is absent, compute base index = lookup_pc[IDX_W+1:2] (bimodal).
REQ-018 SHALL, on upd_valid, set table[upd_idx] to min(cnt+1, 2^CNT_W-1) if upd_taken, otherwise to max(cnt-1, 0).
REQ-019 SHALL leave all state unchanged when upd_valid=0; upd_* inputs are ignored.
REQ-020 SHALL, when a lookup and an update address the same index in one cycle, return the pre-update value (read-before-write); the new value is visible next cycle.
REQ-021 SHALL increment mispred_cnt on upd_valid & upd_mispredict, saturating at 16'hFFFF.
REQ-022 SHALL make upd_mispredict without upd_valid have no effect.

Reset
REQ-023 SHALL, on reset, set every counter to 0 (strongly not taken), history to 0, and mispred_cnt to 0 in one cycle.
REQ-024 SHALL give reset priority over a coincident update; an update during the reset cycle is discarded.
REQ-025 SHALL drive pred_taken=0 for every PC in the cycle after reset.

Configuration
REQ-026 SHALL, with macro BP_GSHARE_EN defined, include a HIST_W-bit global history register (GHR).
REQ-027 SHALL, with BP_GSHARE_EN defined, compute index = lookup_pc[IDX_W+1:2] XOR zero-extended GHR.
REQ-028 SHALL, with BP_GSHARE_EN defined, shift the GHR on upd_valid as {ghr[HIST_W-2:0], upd_taken}; for HIST_W=1, ghr = upd_taken.
REQ-029 SHALL, without BP_GSHARE_EN, contain no GHR logic and use the bimodal index of REQ-017.

Structure
REQ-030 SHALL place in shared package bp_pkg: counter encodings SNT/WNT/WT/ST for CNT_W=2, and helper function clog2-based index width.
REQ-031 SHALL implement the saturating next-value logic (inputs cnt and taken, parameter CNT_W) in sub-module bp_sat_counter, instantiated once on the update path.
REQ-032 SHALL implement the table as a flop array so that single-cycle reset is possible.

Verification
REQ-033 SHALL verify training: after reset, 2 updates (idx=5, taken=1) -> counter 5 = 2'b10 and pred_taken=1 for pc=0x14; a 3rd and 4th taken update hold it at 2'b11.
REQ-034 SHALL verify de-saturation: from counter=3 at idx 5, one not-taken update -> pred_taken stays 1; a second -> pred_taken=0; further updates floor at 0.
REQ-035 SHALL verify the read/write collision: lookup pc=0x14 and update idx=5 taken in the same cycle with counter=1 -> pred_taken=0 that cycle and 1 the next.
REQ-036 SHALL verify mispredict saturation: 65537 updates with upd_mispredict=1 -> mispred_cnt=16'hFFFF; pulses with upd_valid=0 -> no change.
REQ-037 SHALL verify reset mid-run: reset asserted together with upd_valid -> all counters 0, mispred_cnt=0, update lost.
REQ-038 SHALL verify gshare (BP_GSHARE_EN, HIST_W=6): updates taken,taken,not-taken -> GHR=6'b000110; lookup pc=0x14 -> pred_idx=5^6=3.
